// File: rtl/riscv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fetch_pkg
//   Shared definitions for the instruction-fetch path.
//   XLEN          : architectural register / address width (32)
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) driven when no instruction is valid
//   fetch_entry_t : one fetch-queue slot {pc, instr, filled}
// -----------------------------------------------------------------------------
package riscv_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage : riscv_fetch_pkg

// File: rtl/ifq_storage.sv
// -----------------------------------------------------------------------------
// ifq_storage
//   DEPTH-entry in-order fetch buffer. Slots are allocated when a fetch is
//   granted (PC known, word not yet returned), filled in allocation order as
//   words come back, and popped from the head once filled.
//   Ports:
//     clk_i, rst_i     clock, asynchronous active-high reset
//     flush_i          discard every slot (takes priority over alloc/fill/pop)
//     alloc_i          allocate slot at the write pointer with alloc_pc_i
//     fill_i           write fill_instr_i into the oldest unfilled slot
//     pop_i            retire the head slot (must be filled)
//     head_o           head slot contents
//     count_o          occupied slots, including unfilled ones
//     unfilled_o       slots allocated but still waiting for their word
// -----------------------------------------------------------------------------
module ifq_storage
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               alloc_i,
  input  logic [XLEN-1:0]    alloc_pc_i,
  input  logic               fill_i,
  input  logic [XLEN-1:0]    fill_instr_i,
  input  logic               pop_i,
  output fetch_entry_t       head_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [CNT_W-1:0]   unfilled_o
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [CNT_W-1:0] unfilled_q, unfilled_d;

  // The three pointers always address distinct slots when they act together:
  // alloc only happens below DEPTH, a fill targets an older unfilled slot, and
  // a pop targets a filled one. So the writes below never collide.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;

    if (flush_i) begin
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      unfilled_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].filled = 1'b0;
      end
    end else begin
      if (alloc_i) begin
        mem_d[wr_ptr_q] = '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (fill_i) begin
        mem_d[fill_ptr_q].instr  = fill_instr_i;
        mem_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d               = fill_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        // Clearing filled on pop keeps head_o.filled an exact valid flag.
        mem_d[rd_ptr_q].filled = 1'b0;
        rd_ptr_d               = rd_ptr_q + PTR_W'(1);
      end
      count_d    = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  // NOTE: the slot array is reset too; it is only a few entries and this makes
  // pc_o read zero out of reset instead of power-up garbage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign unfilled_o = unfilled_q;

endmodule : ifq_storage

// File: rtl/ifid_fetch_queue.sv
// -----------------------------------------------------------------------------
// ifid_fetch_queue
//   Fetch stage between the PC register and decode. Requests pc_i from
//   instruction memory whenever a queue slot is free (slots are credits, so
//   outstanding fetches can never overflow the queue), buffers returned words
//   in order with their PCs and presents the oldest one to decode, holding it
//   while decode stalls. A redirect (flush_i) empties the queue and counts the
//   still-outstanding responses so they are discarded when they arrive.
//   Optional feature macro: IFQ_PERF_CNT_EN adds stall_cnt_o and the CNT_W
//   parameter, a saturating count of cycles with valid_o & stall_i.
//   Ports:
//     clk_i, rst_i                  clock, asynchronous active-high reset
//     pc_i                          current PC from the PC register
//     pc_adv_o                      PC accepted this cycle; PC may advance
//     imem_req_o / imem_addr_o      fetch request and address (= pc_i)
//     imem_gnt_i                    memory accepts the request
//     imem_rvalid_i / imem_rdata_i  in-order response word
//     flush_i                       redirect: drop queue and in-flight fetches
//     stall_i                       decode hazard: hold the presented word
//     valid_o, pc_o, instr_o        presented instruction (NOP when invalid)
//     stall_cnt_o                   decode stall cycles (IFQ_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module ifid_fetch_queue
  import riscv_fetch_pkg::XLEN, riscv_fetch_pkg::fetch_entry_t;
#(
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_fetch_pkg::NOP_INSTR
`ifdef IFQ_PERF_CNT_EN
  ,parameter int             CNT_W     = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              pc_adv_o,
  output logic              imem_req_o,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [XLEN-1:0]   imem_rdata_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   instr_o
`ifdef IFQ_PERF_CNT_EN
  ,output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int QCNT_W = $clog2(DEPTH + 1);
  // Worst case: a full queue of unfilled slots flushed while an earlier
  // flush still has DEPTH responses owed.
  localparam int DROP_W = $clog2(2 * DEPTH + 1);

  fetch_entry_t      head;
  logic [QCNT_W-1:0] count;
  logic [QCNT_W-1:0] unfilled;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              grant;
  logic              pop;
  logic              rv_drop;
  logic              rv_fill;

  assign imem_req_o  = ~rst_i & ~flush_i & (count < QCNT_W'(DEPTH));
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o & imem_gnt_i;
  assign pc_adv_o    = grant;

  assign valid_o = head.filled;
  assign pc_o    = head.pc;
  assign instr_o = valid_o ? head.instr : NOP_INSTR;
  assign pop     = valid_o & ~stall_i & ~flush_i;

  // A response first pays off owed drops; only then does it belong to the
  // oldest live unfilled slot.
  assign rv_drop = imem_rvalid_i & (drop_cnt_q != '0);
  assign rv_fill = imem_rvalid_i & (drop_cnt_q == '0) & (unfilled != '0);

  // On flush every unfilled slot becomes an owed response, except one already
  // answered by a response arriving in the flush cycle itself.
  always_comb begin
    drop_cnt_d = drop_cnt_q - DROP_W'(rv_drop);
    if (flush_i) begin
      drop_cnt_d = drop_cnt_d + DROP_W'(unfilled) - DROP_W'(rv_fill);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .alloc_i      (grant),
    .alloc_pc_i   (pc_i),
    .fill_i       (rv_fill),
    .fill_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

  // A response with nothing outstanding and nothing owed is a memory-side
  // protocol violation; the queue ignores it.
  a_rvalid_expected: assert property (
    @(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> ((drop_cnt_q != '0) || (unfilled != '0))
  );

`ifdef IFQ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_o && stall_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : ifid_fetch_queue

// File: tb/tb_ifid_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_ifid_fetch_queue
//   Scoreboard bench for ifid_fetch_queue. The driver issues one cycle of
//   stimulus at each falling edge and keeps a transaction-level model: a list
//   of granted-but-unanswered PCs, a count of owed responses after redirects,
//   and the scoreboard queue of {pc, instr} that decode must see in order.
//   A separate monitor compares whatever the DUT presents against the
//   scoreboard head and retires it when decode accepts it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ns

module tb_ifid_fetch_queue;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_adv_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        stall_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
`ifdef IFQ_PERF_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  ifid_fetch_queue dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_adv_o      (pc_adv_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .instr_o       (instr_o)
`ifdef IFQ_PERF_CNT_EN
    ,.stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          ready;   // first cycle the word may be presented
  } exp_t;

  exp_t        exp_q[$];   // returned words decode must still see
  logic [31:0] pend_q[$];  // granted PCs still waiting for their word
  int          drop_m;     // responses owed to earlier redirects
  int          stall_m;
  logic [31:0] next_pc;
  int          cyc;
  int          errors;
  int          checks;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus. rv is only honoured when a response is legal.
  task automatic step(input logic gnt, input logic rv, input logic fl,
                      input logic st, input logic [31:0] fl_pc);
    logic rv_ok;
    logic req_m;
    int   occ;
    exp_t e;
    @(negedge clk_i);
    rv_ok         = rv && (drop_m > 0 || pend_q.size() > 0);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv_ok;
    imem_rdata_i  = $urandom();
    flush_i       = fl;
    stall_i       = st;
    pc_i          = next_pc;
    #1;
    occ   = pend_q.size() + exp_q.size();
    req_m = !fl && (occ < DEPTH);
    check("imem_req_o", imem_req_o, req_m);
    check("pc_adv_o", pc_adv_o, req_m && gnt);
    check("imem_addr_o", imem_addr_o, next_pc);
    #2;  // monitor has retired this cycle's accepted word by now
    if (rv_ok) begin
      if (drop_m > 0) begin
        drop_m--;
      end else begin
        e.pc    = pend_q.pop_front();
        e.instr = imem_rdata_i;
        e.ready = cyc + 1;
        exp_q.push_back(e);
      end
    end
    if (fl) begin
      drop_m += pend_q.size();
      pend_q.delete();
      exp_q.delete();
      next_pc = fl_pc;
    end else if (req_m && gnt) begin
      pend_q.push_back(next_pc);
      next_pc += 32'd4;
    end
  endtask

  // Asynchronous reset with responses still arriving while it is held.
  task automatic apply_reset();
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    flush_i       = 1'b0;
    stall_i       = 1'b0;
    #1;
    check("rst_imem_req_o", imem_req_o, 1'b0);
    check("rst_pc_adv_o", pc_adv_o, 1'b0);
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_pc_o", pc_o, 32'h0);
    check("rst_instr_o", instr_o, NOP_INSTR);
`ifdef IFQ_PERF_CNT_EN
    check("rst_stall_cnt_o", stall_cnt_o, 32'h0);
`endif
    pend_q.delete();
    exp_q.delete();
    drop_m  = 0;
    stall_m = 0;
    next_pc = 32'h0;
    pc_i    = 32'h0;
    repeat (2) begin
      @(negedge clk_i);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = $urandom();
      imem_gnt_i    = 1'b1;
      #1;
      check("rst_hold_req", imem_req_o, 1'b0);
    end
    @(negedge clk_i);
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b0;
    rst_i         = 1'b0;
  endtask

  // Monitor: compares the presented instruction with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL valid_o: presented pc %h instr %h but none expected (cycle %0d)",
                     pc_o, instr_o, cyc);
          end else begin
            check("pc_o", pc_o, exp_q[0].pc);
            check("instr_o", instr_o, exp_q[0].instr);
            if (!stall_i) void'(exp_q.pop_front());
          end
        end else begin
          check("instr_o_nop", instr_o, NOP_INSTR);
          if (exp_q.size() > 0 && exp_q[0].ready <= cyc) begin
            check("valid_o_latency", valid_o, 1'b1);
          end
        end
`ifdef IFQ_PERF_CNT_EN
        check("stall_cnt_o", stall_cnt_o, stall_m);
        if (valid_o && stall_i && stall_m < 32'hFFFF) stall_m++;
`endif
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    pc_i   = 32'h0;
    imem_rdata_i = 32'h0;
    apply_reset();

    // Continuous grant, one-cycle response: back-to-back delivery.
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // No responses: credits run out after DEPTH grants, then resume.
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Decode stall with the queue filling behind the held word.
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect with two fetches in flight; their responses must be dropped.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Second redirect while one response is still owed.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Reset mid-stream with three fetches outstanding.
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Randomised traffic, with one more reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) apply_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 3,
           $urandom() & 32'hFFFF_FFFC);
    end
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ifid_fetch_queue
